// File: rtl/mining_pkg.sv
// Shared types and constants for the double-SHA256 work sequencer.
package mining_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam logic [31:0] GOLDEN_MATCH         = 32'hA41F32E7;
    localparam int          DEFAULT_PIPE_LATENCY = 253;

endpackage

// File: rtl/golden_nonce_fifo.sv
// Small synchronous FIFO for golden nonces; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module golden_nonce_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hash_work_sequencer.sv
// Feeds the double-SHA256 hasher one nonce per cycle over an inclusive range
// and collects golden nonces, aligning result checks to the pipeline latency.
module hash_work_sequencer
    import mining_pkg::*;
#(
    parameter int          PIPE_LATENCY = DEFAULT_PIPE_LATENCY,
    parameter logic [31:0] GOLDEN_MATCH = mining_pkg::GOLDEN_MATCH,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic         hash_clk,
    input  logic         reset,
    input  logic         new_work,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce_start,
    input  logic [31:0]  work_nonce_end,
    output logic [255:0] hs_midstate,
    output logic [95:0]  hs_data,
    output logic [31:0]  hs_nonce,
    input  logic [31:0]  hash2_w,
    output logic         gn_valid,
    output logic [31:0]  gn_nonce,
    input  logic         gn_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int LAT_W = $clog2(PIPE_LATENCY + 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [31:0]      nonce_end;
    logic [31:0]      chk_nonce;
    logic [32:0]      issue_cnt;
    logic [32:0]      chk_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_full;
    logic             issuing;
    logic             last_issue;
    logic             check_en;
    logic             match_q;
    logic [31:0]      match_nonce_q;
    logic             match_last_q;
    logic             last_checked_q;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign issuing    = (state == RUN);
    assign last_issue = issuing && (hs_nonce == nonce_end);
    assign lat_full   = (lat_cnt == LAT_W'(PIPE_LATENCY));
    // A result is ours only once the pipeline has filled and while some
    // issued nonce is still unchecked.
    assign check_en   = (state != IDLE) && lat_full && (chk_cnt < issue_cnt);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            IDLE:  if (new_work) state_next = RUN;
            RUN: begin
                if (new_work)        state_next = RUN;
                else if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                if (new_work) begin
                    state_next = RUN;
                end else if (last_checked_q) begin
                    state_next = IDLE;
                    done       = !reset;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state          <= IDLE;
            hs_midstate    <= '0;
            hs_data        <= '0;
            hs_nonce       <= '0;
            nonce_end      <= '0;
            chk_nonce      <= '0;
            issue_cnt      <= '0;
            chk_cnt        <= '0;
            lat_cnt        <= '0;
            match_q        <= 1'b0;
            match_nonce_q  <= '0;
            match_last_q   <= 1'b0;
            last_checked_q <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            state <= state_next;
            if (new_work) begin
                hs_midstate    <= work_midstate;
                hs_data        <= work_data;
                hs_nonce       <= work_nonce_start;
                nonce_end      <= work_nonce_end;
                chk_nonce      <= work_nonce_start;
                issue_cnt      <= '0;
                chk_cnt        <= '0;
                lat_cnt        <= '0;
                match_q        <= 1'b0;
                match_last_q   <= 1'b0;
                last_checked_q <= 1'b0;
                overflow       <= 1'b0;
            end else begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + 33'd1;
                    if (!last_issue) hs_nonce <= hs_nonce + 32'd1;
                end
                if (busy && !lat_full) lat_cnt <= lat_cnt + LAT_W'(1);
                match_q        <= check_en && (hash2_w == GOLDEN_MATCH);
                match_last_q   <= check_en && (chk_nonce == nonce_end);
                match_nonce_q  <= chk_nonce;
                last_checked_q <= match_last_q;
                if (check_en) begin
                    chk_nonce <= chk_nonce + 32'd1;
                    chk_cnt   <= chk_cnt + 33'd1;
                end
                if (push && fifo_full && !pop) overflow <= 1'b1;
            end
        end
    end

    // gn_* handshake: gn_nonce is the FIFO head and holds while gn_valid is
    // high; an entry leaves on any edge where gn_valid and gn_ready are both 1.
    assign gn_valid = !fifo_empty;
    assign pop      = gn_valid && gn_ready;
    assign push     = match_q && !new_work;

    golden_nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (hash_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (match_nonce_q),
        .dout  (gn_nonce),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_hash_work_sequencer.sv
// Bench for hash_work_sequencer: delay-line hasher model, golden-nonce
// scoreboard and per-scenario tasks.
module tb_hash_work_sequencer;

    localparam int          L      = 8;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] GOLDEN = 32'hA41F32E7;

    logic         hash_clk;
    logic         reset;
    logic         new_work;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start;
    logic [31:0]  work_nonce_end;
    logic [255:0] hs_midstate;
    logic [95:0]  hs_data;
    logic [31:0]  hs_nonce;
    logic [31:0]  hash2_w;
    logic         gn_valid;
    logic [31:0]  gn_nonce;
    logic         gn_ready;
    logic         busy;
    logic         done;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic [31:0]  issued_q[$];
    logic [255:0] cur_mid;
    logic [95:0]  cur_data;

    bit          golden_map [logic [31:0]];
    bit          stale_en;
    int          stale_left;
    logic [31:0] hist [L];

    hash_work_sequencer #(
        .PIPE_LATENCY (L),
        .GOLDEN_MATCH (GOLDEN),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .hash_clk         (hash_clk),
        .reset            (reset),
        .new_work         (new_work),
        .work_midstate    (work_midstate),
        .work_data        (work_data),
        .work_nonce_start (work_nonce_start),
        .work_nonce_end   (work_nonce_end),
        .hs_midstate      (hs_midstate),
        .hs_data          (hs_data),
        .hs_nonce         (hs_nonce),
        .hash2_w          (hash2_w),
        .gn_valid         (gn_valid),
        .gn_nonce         (gn_nonce),
        .gn_ready         (gn_ready),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    // Clock / reset
    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    // Hasher model: result for the nonce presented L cycles ago; optionally
    // emits GOLDEN for L cycles after new_work to mimic stale pipeline data.
    always @(posedge hash_clk) begin
        if (stale_left > 0 || (stale_en && new_work))
            hash2_w <= GOLDEN;
        else if (golden_map.exists(hist[L-2]))
            hash2_w <= GOLDEN;
        else
            hash2_w <= 32'h0BADF00D;
        for (int i = L - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= hs_nonce;
        if (stale_en && new_work) stale_left <= L - 1;
        else if (stale_left > 0)  stale_left <= stale_left - 1;
    end

    // Scoreboard capture of every popped golden nonce
    always @(posedge hash_clk) begin
        if (!reset && gn_valid === 1'b1 && gn_ready === 1'b1) got_q.push_back(gn_nonce);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic start_work(input logic [31:0] s, input logic [31:0] e);
        cur_mid  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cur_data = {$urandom, $urandom, $urandom};
        work_midstate    = cur_mid;
        work_data        = cur_data;
        work_nonce_start = s;
        work_nonce_end   = e;
        new_work = 1'b1;
        tick();
        new_work = 1'b0;
        work_midstate    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        work_data        = {$urandom, $urandom, $urandom};
        work_nonce_start = $urandom;
        work_nonce_end   = $urandom;
    endtask

    // Reference model: goldens reported in range order, one per nonce.
    task automatic model_expect(input logic [31:0] s, input int n);
        logic [31:0] x;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            x = s + 32'(k);
            if (golden_map.exists(x)) exp_q.push_back(x);
        end
    endtask

    task automatic wait_done(input int n_issue, input int max_cyc, output int done_cyc, output int first_valid);
        int n = 0;
        done_cyc    = -1;
        first_valid = -1;
        issued_q.delete();
        forever begin
            if (n < n_issue) issued_q.push_back(hs_nonce);
            if (gn_valid === 1'b1 && first_valid < 0) first_valid = n;
            if (done === 1'b1) begin
                done_cyc = n;
                break;
            end
            if (n >= max_cyc) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (hs_nonce !== 32'h0) begin failures++; $display("FAIL reset_hs_nonce: got %h want 0", hs_nonce); end
        checks++; if (hs_midstate !== 256'h0) begin failures++; $display("FAIL reset_hs_midstate: got %h want 0", hs_midstate); end
        checks++; if (hs_data !== 96'h0) begin failures++; $display("FAIL reset_hs_data: got %h want 0", hs_data); end
        checks++; if (gn_valid !== 1'b0) begin failures++; $display("FAIL reset_gn_valid: got %b want 0", gn_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int dc, fv, bad;
        golden_map.delete();
        golden_map[32'h15] = 1'b1;
        gn_ready = 1'b1;
        got_q.delete();
        model_expect(32'h10, 16);
        start_work(32'h10, 32'h1F);
        checks++; if (hs_nonce !== 32'h10) begin failures++; $display("FAIL basic_first_nonce: got %h want 10", hs_nonce); end
        checks++; if (hs_midstate !== cur_mid) begin failures++; $display("FAIL basic_midstate: got %h want %h", hs_midstate, cur_mid); end
        checks++; if (hs_data !== cur_data) begin failures++; $display("FAIL basic_data: got %h want %h", hs_data, cur_data); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        wait_done(16, 80, dc, fv);
        checks++; if (dc != 16 + L + 1) begin failures++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, 16 + L + 1); end
        checks++; if (fv != 5 + L + 2) begin failures++; $display("FAIL basic_gn_valid_cycle: got %0d want %0d", fv, 5 + L + 2); end
        bad = (issued_q.size() != 16) ? 1 : 0;
        for (int k = 0; k < issued_q.size() && k < 16; k++) if (issued_q[k] !== 32'h10 + 32'(k)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL basic_issue_seq: %0d wrong nonces, want 0", bad); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_busy_fall: got busy=%b done=%b want 0/0", busy, done); end
        tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_gn_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_gn_nonce: got %h want %h", got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        int dc, fv, bad;
        logic [31:0] want;
        golden_map.delete();
        golden_map[32'h0] = 1'b1;
        got_q.delete();
        model_expect(32'hFFFFFFFE, 4);
        start_work(32'hFFFFFFFE, 32'h00000001);
        wait_done(4, 60, dc, fv);
        checks++; if (dc != 4 + L + 1) begin failures++; $display("FAIL wrap_done_cycle: got %0d want %0d", dc, 4 + L + 1); end
        bad = (issued_q.size() != 4) ? 1 : 0;
        for (int k = 0; k < issued_q.size() && k < 4; k++) begin
            want = 32'hFFFFFFFE + 32'(k);
            if (issued_q[k] !== want) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL wrap_issue_seq: %0d wrong nonces, want 0", bad); end
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_fall: got %b want 0", busy); end
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            failures++; $display("FAIL wrap_gn_count: got %0d want 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL wrap_gn_nonce: got %h want %h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_flush();
        int dc, fv;
        golden_map.delete();
        got_q.delete();
        stale_en = 1'b1;
        start_work(32'h100, 32'h107);
        stale_en = 1'b0;
        wait_done(8, 60, dc, fv);
        checks++; if (dc != 8 + L + 1) begin failures++; $display("FAIL flush_done_cycle: got %0d want %0d", dc, 8 + L + 1); end
        checks++; if (fv != -1) begin failures++; $display("FAIL flush_gn_valid: went high at cycle %0d, want never", fv); end
        repeat (2) tick();
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL flush_push: got %0d entries want 0", got_q.size()); end
    endtask

    task automatic test_abort();
        int dc, fv, n;
        bit saw_done;
        golden_map.delete();
        golden_map[32'h3C]   = 1'b1;
        golden_map[32'h1001] = 1'b1;
        got_q.delete();
        start_work(32'h0, 32'hFF);
        n = 0;
        saw_done = 1'b0;
        while (hs_nonce !== 32'h40 && n < 100) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
            n++;
        end
        checks++; if (hs_nonce !== 32'h40) begin failures++; $display("FAIL abort_reach: got %h want 40", hs_nonce); end
        model_expect(32'h1000, 4);
        start_work(32'h1000, 32'h1003);
        checks++; if (hs_nonce !== 32'h1000) begin failures++; $display("FAIL abort_restart_nonce: got %h want 1000", hs_nonce); end
        wait_done(4, 60, dc, fv);
        checks++; if (saw_done) begin failures++; $display("FAIL abort_first_done: got 1 want 0"); end
        checks++; if (dc != 4 + L + 1) begin failures++; $display("FAIL abort_done_cycle: got %0d want %0d", dc, 4 + L + 1); end
        repeat (2) tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL abort_gn_count: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_gn_nonce: got %h want %h", got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_overflow();
        int dc, fv;
        logic [31:0] s;
        s = $urandom;
        golden_map.delete();
        for (int k = 2; k < 8; k++) golden_map[s + 32'(k)] = 1'b1;
        got_q.delete();
        gn_ready = 1'b0;
        model_expect(s, 10);
        start_work(s, s + 32'd9);
        wait_done(10, 60, dc, fv);
        checks++; if (dc != 10 + L + 1) begin failures++; $display("FAIL ovf_done_cycle: got %0d want %0d", dc, 10 + L + 1); end
        checks++; if (overflow !== (exp_q.size() > DEPTH)) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        repeat (3) tick();
        checks++; if (gn_valid !== 1'b1 || gn_nonce !== exp_q[0]) begin failures++; $display("FAIL ovf_head_stable: got v=%b %h want 1 %h", gn_valid, gn_nonce, exp_q[0]); end
        gn_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        checks++; if (gn_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %b want 0", gn_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        checks++;
        if (got_q.size() != DEPTH) begin
            failures++; $display("FAIL ovf_gn_count: got %0d want %0d", got_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_gn_order: got %h want %h", got_q[i], exp_q[i]); end
            end
        end
        golden_map.delete();
        start_work(s + 32'd100, s + 32'd100);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        wait_done(1, 40, dc, fv);
        checks++; if (dc != 1 + L + 1) begin failures++; $display("FAIL single_done_cycle: got %0d want %0d", dc, 1 + L + 1); end
        tick();
    endtask

    task automatic test_reset_drain();
        int done_cnt, busy_cnt;
        logic [31:0] s;
        s = $urandom;
        golden_map.delete();
        golden_map[s] = 1'b1;
        gn_ready = 1'b0;
        start_work(s, s + 32'd3);
        repeat (11) tick();
        checks++; if (busy !== 1'b1 || gn_valid !== 1'b1) begin failures++; $display("FAIL rd_pre: got busy=%b gn_valid=%b want 1/1", busy, gn_valid); end
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || gn_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 ||
            hs_nonce !== 32'h0 || hs_midstate !== 256'h0 || hs_data !== 96'h0) begin
            failures++;
            $display("FAIL rd_reset_values: got busy=%b gv=%b done=%b ovf=%b nonce=%h want all 0",
                     busy, gn_valid, done, overflow, hs_nonce);
        end
        reset = 1'b0;
        gn_ready = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (done_cnt != 0 || busy_cnt != 0) begin failures++; $display("FAIL rd_no_done: got done=%0d busy=%0d cycles want 0/0", done_cnt, busy_cnt); end
    endtask

    task automatic test_random();
        int dc, fv, n, bad, want_fv;
        logic [31:0] s;
        for (int it = 0; it < 6; it++) begin
            s = (it == 0) ? 32'hFFFFFFF0 : $urandom;
            n = $urandom_range(1, 24);
            golden_map.delete();
            for (int k = 0; k < n; k++) if ($urandom_range(0, 3) == 0) golden_map[s + 32'(k)] = 1'b1;
            gn_ready = 1'b1;
            got_q.delete();
            model_expect(s, n);
            want_fv = (exp_q.size() > 0) ? int'(exp_q[0] - s) + L + 2 : -1;
            start_work(s, s + 32'(n - 1));
            wait_done(n, n + L + 20, dc, fv);
            checks++; if (dc != n + L + 1) begin failures++; $display("FAIL rnd_done_cycle: got %0d want %0d", dc, n + L + 1); end
            checks++; if (fv != want_fv) begin failures++; $display("FAIL rnd_gn_valid_cycle: got %0d want %0d", fv, want_fv); end
            bad = (issued_q.size() != n) ? 1 : 0;
            for (int k = 0; k < issued_q.size() && k < n; k++) if (issued_q[k] !== s + 32'(k)) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rnd_issue_seq: %0d wrong nonces, want 0", bad); end
            tick();
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_busy_fall: got %b want 0", busy); end
            tick();
            checks++;
            if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL rnd_gn_count: got %0d want %0d", got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_gn_nonce: got %h want %h", got_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        new_work         = 1'b0;
        work_midstate    = '0;
        work_data        = '0;
        work_nonce_start = '0;
        work_nonce_end   = '0;
        gn_ready         = 1'b1;
        stale_en         = 1'b0;
        stale_left       = 0;
        hash2_w          = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_flush();
        test_abort();
        test_overflow();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
